// File: rtl/swio_pkg.sv
// Shared types and constants for the switch-input responder: FSM encoding, status bit
// positions and default read addresses.
package swio_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 32;

    localparam int unsigned READY_BIT   = 0;
    localparam int unsigned OVERRUN_BIT = 1;

    localparam logic [ADDR_W-1:0] DEF_DATA_ADDR    = 16'h8000;
    localparam logic [ADDR_W-1:0] DEF_STAT_ADDR    = 16'h8001;
    localparam logic [ADDR_W-1:0] LIVE_ADDR_OFFSET = 16'h0002;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        DEBOUNCE     = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } swio_state_e;

endpackage

// File: rtl/switch_io_responder_if.sv
// CPU switch-read port: address and strobe from the CPU, read data back from the peripheral.
interface switch_io_responder_if;
    import swio_pkg::*;

    logic [ADDR_W-1:0] read_address;
    logic              read_enable;
    logic [DATA_W-1:0] SWData;

    modport master (output read_address, output read_enable, input SWData);
    modport slave  (input read_address, input read_enable, output SWData);

endinterface

// File: rtl/swio_debounce.sv
// Commit-button debouncer: 2-FF synchronizer, press/release FSM, one-cycle commit pulse.
module swio_debounce
    import swio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_commit,
    output logic commit
);

    localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_meta;
    logic             btn_s;
    swio_state_e      state;
    swio_state_e      state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
        end else begin
            btn_meta <= btn_commit;
            btn_s    <= btn_meta;
        end
    end

    // commit is registered from the next state so it is high exactly while in PRESSED
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            commit <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            commit <= (state_d == PRESSED);
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_d = DEBOUNCE;
                    cnt_d   = '0;
                end
            end
            DEBOUNCE: begin
                if (!btn_s)                state_d = IDLE;
                else if (cnt == CNT_LAST)  state_d = PRESSED;
                else                       cnt_d   = cnt + CNT_W'(1);
            end
            PRESSED: begin
                state_d = WAIT_RELEASE;
                cnt_d   = '0;
            end
            WAIT_RELEASE: begin
                // any high sample restarts the release window, so chatter cannot re-arm
                if (btn_s)                 cnt_d   = '0;
                else if (cnt == CNT_LAST)  state_d = IDLE;
                else                       cnt_d   = cnt + CNT_W'(1);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/switch_io_responder.sv
// Memory-mapped switch peripheral: latches the switch bank on each debounced commit press.
// Optional SWIO_LIVE_READ_EN maps the live synchronized switches at DATA_ADDR+2.
module switch_io_responder
    import swio_pkg::*;
#(
    parameter int unsigned       SW_WIDTH        = 16,
    parameter int unsigned       DEBOUNCE_CYCLES = 20000,
    parameter logic [ADDR_W-1:0] DATA_ADDR       = DEF_DATA_ADDR,
    parameter logic [ADDR_W-1:0] STAT_ADDR       = DEF_STAT_ADDR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SW_WIDTH-1:0]  sw,
    input  logic                 btn_commit,
    switch_io_responder_if.slave bus,
    output logic                 ready_led
);

    logic [SW_WIDTH-1:0] sw_meta;
    logic [SW_WIDTH-1:0] sw_s;
    logic [SW_WIDTH-1:0] data_reg;
    logic                ready;
    logic                overrun;
    logic                commit;
    logic                data_rd;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_meta <= '0;
            sw_s    <= '0;
        end else begin
            sw_meta <= sw;
            sw_s    <= sw_meta;
        end
    end

    swio_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .clk        (clk),
        .rst        (rst),
        .btn_commit (btn_commit),
        .commit     (commit)
    );

    assign data_rd = bus.read_enable && (bus.read_address == DATA_ADDR);

    // A commit on the same edge as a data read wins: the CPU took the old value, so no overrun.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_reg <= '0;
            ready    <= 1'b0;
            overrun  <= 1'b0;
        end else if (commit) begin
            data_reg <= sw_s;
            ready    <= 1'b1;
            if (data_rd)    overrun <= 1'b0;
            else if (ready) overrun <= 1'b1;
        end else if (data_rd) begin
            ready   <= 1'b0;
            overrun <= 1'b0;
        end
    end

    always_comb begin
        bus.SWData = '0;
        if (bus.read_address == DATA_ADDR) begin
            bus.SWData = DATA_W'(data_reg);
        end else if (bus.read_address == STAT_ADDR) begin
            bus.SWData[READY_BIT]   = ready;
            bus.SWData[OVERRUN_BIT] = overrun;
        end
`ifdef SWIO_LIVE_READ_EN
        else if (bus.read_address == DATA_ADDR + LIVE_ADDR_OFFSET) begin
            bus.SWData = DATA_W'(sw_s);
        end
`endif
    end

    assign ready_led = ready;

endmodule

// File: tb/tb_switch_io_responder.sv
// Self-checking bench for switch_io_responder with a run-length reference model of the
// debouncer; directed scenarios followed by randomized button/switch/read traffic.
module tb_switch_io_responder;
    import swio_pkg::*;

    localparam int unsigned N = 4;

    logic        clk;
    logic        rst;
    logic [15:0] sw;
    logic        btn;
    logic        ready_led;

    switch_io_responder_if bus_if ();

    switch_io_responder #(
        .SW_WIDTH        (16),
        .DEBOUNCE_CYCLES (N),
        .DATA_ADDR       (16'h8000),
        .STAT_ADDR       (16'h8001)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .btn_commit (btn),
        .bus        (bus_if.slave),
        .ready_led  (ready_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: synchronizer pipes plus run lengths of the synchronized button.
    logic [15:0] m_sw_p0, m_sw_s, m_data;
    logic        m_b_p0, m_b_s;
    bit          m_ready, m_ovr;
    bit          m_armed, m_ignore, m_commit_next;
    int          m_run;

    function automatic void model_edge();
        bit commit_now;
        bit rd;
        if (!rst) begin
            m_sw_p0 = '0; m_sw_s = '0; m_b_p0 = 1'b0; m_b_s = 1'b0;
            m_data = '0; m_ready = 0; m_ovr = 0;
            m_armed = 1; m_ignore = 0; m_commit_next = 0; m_run = 0;
            return;
        end
        commit_now    = m_commit_next;
        m_commit_next = 0;
        rd = bus_if.read_enable && (bus_if.read_address == 16'h8000);
        if (commit_now) begin
            if (rd)           m_ovr = 0;
            else if (m_ready) m_ovr = 1;
            m_data  = m_sw_s;
            m_ready = 1;
        end else if (rd) begin
            m_ready = 0;
            m_ovr   = 0;
        end
        if (m_ignore) begin
            m_ignore = 0;
            m_run    = 0;
        end else if (m_armed) begin
            m_run = m_b_s ? m_run + 1 : 0;
            if (m_run == int'(N) + 1) begin
                m_commit_next = 1; m_armed = 0; m_ignore = 1; m_run = 0;
            end
        end else begin
            m_run = m_b_s ? 0 : m_run + 1;
            if (m_run == int'(N)) begin
                m_armed = 1; m_run = 0;
            end
        end
        m_sw_s = m_sw_p0; m_sw_p0 = sw;
        m_b_s  = m_b_p0;  m_b_p0  = btn;
    endfunction

    function automatic logic [31:0] model_swdata(input logic [15:0] a);
        if (a == 16'h8000) return {16'h0, m_data};
        if (a == 16'h8001) return {30'h0, m_ovr, m_ready};
`ifdef SWIO_LIVE_READ_EN
        if (a == 16'h8002) return {16'h0, m_sw_s};
`endif
        return 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_addr(input logic [15:0] a, input logic en);
        bus_if.read_address = a;
        bus_if.read_enable  = en;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; sw = 16'hFFFF; btn = 1'b0;
        set_addr(16'h8000, 1'b0);
        ticks(2);
        n_cmp++; if (bus_if.SWData !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want %h", bus_if.SWData, 32'h0); end
        n_cmp++; if (ready_led !== 1'b0) begin n_err++; $display("FAIL reset_led got %b want 0", ready_led); end
        set_addr(16'h8001, 1'b0);
        n_cmp++; if (bus_if.SWData !== 32'h0) begin n_err++; $display("FAIL reset_stat got %h want %h", bus_if.SWData, 32'h0); end
        set_addr(16'h8002, 1'b0);
        n_cmp++; if (bus_if.SWData !== 32'h0) begin n_err++; $display("FAIL reset_live got %h want %h", bus_if.SWData, 32'h0); end
        rst = 1'b1;
        ticks(3);
        n_cmp++; if (bus_if.SWData !== model_swdata(16'h8002)) begin n_err++; $display("FAIL live_tap got %h want %h", bus_if.SWData, model_swdata(16'h8002)); end
    endtask

    task automatic test_commit_read();
        sw = 16'hA5C3;
        set_addr(16'h8001, 1'b0);
        btn = 1'b1;
        ticks(N + 3);
        n_cmp++; if (ready_led !== 1'b0) begin n_err++; $display("FAIL latency_early got %b want 0", ready_led); end
        tick();
        n_cmp++; if (ready_led !== 1'b1) begin n_err++; $display("FAIL latency_ready got %b want 1", ready_led); end
        ticks(20 - (N + 4));
        btn = 1'b0;
        ticks(N + 6);
        n_cmp++; if (bus_if.SWData !== 32'h1) begin n_err++; $display("FAIL stat_ready got %h want %h", bus_if.SWData, 32'h1); end
        set_addr(16'h8000, 1'b1);
        n_cmp++; if (bus_if.SWData !== 32'h0000A5C3) begin n_err++; $display("FAIL data_read got %h want %h", bus_if.SWData, 32'h0000A5C3); end
        tick();
        set_addr(16'h8001, 1'b0);
        n_cmp++; if (bus_if.SWData !== 32'h0) begin n_err++; $display("FAIL stat_cleared got %h want %h", bus_if.SWData, 32'h0); end
        set_addr(16'h8000, 1'b1);
        tick();
        set_addr(16'h8000, 1'b0);
        n_cmp++; if (bus_if.SWData !== 32'h0000A5C3 || ready_led !== 1'b0) begin n_err++; $display("FAIL repeat_read got %h/%b want %h/0", bus_if.SWData, ready_led, 32'h0000A5C3); end
    endtask

    task automatic test_short_pulse();
        btn = 1'b1;
        ticks(3);
        btn = 1'b0;
        ticks(10);
        set_addr(16'h8001, 1'b0);
        n_cmp++; if (bus_if.SWData !== 32'h0 || ready_led !== 1'b0) begin n_err++; $display("FAIL short_pulse got %h/%b want 0/0", bus_if.SWData, ready_led); end
        n_cmp++; if (u_dut.u_deb.state !== IDLE) begin n_err++; $display("FAIL short_idle got %0d want %0d", u_dut.u_deb.state, IDLE); end
    endtask

    task automatic test_two_presses();
        for (int p = 1; p <= 2; p++) begin
            sw = 16'(p);
            btn = 1'b1; ticks(10);
            btn = 1'b0; ticks(10);
        end
        set_addr(16'h8001, 1'b0);
        n_cmp++; if (bus_if.SWData !== 32'h3) begin n_err++; $display("FAIL overrun_stat got %h want %h", bus_if.SWData, 32'h3); end
        set_addr(16'h8000, 1'b1);
        n_cmp++; if (bus_if.SWData !== 32'h2) begin n_err++; $display("FAIL overrun_data got %h want %h", bus_if.SWData, 32'h2); end
        tick();
        set_addr(16'h8001, 1'b0);
        n_cmp++; if (bus_if.SWData !== 32'h0) begin n_err++; $display("FAIL overrun_clear got %h want %h", bus_if.SWData, 32'h0); end
    endtask

    task automatic test_read_at_commit();
        sw = 16'h0005;
        btn = 1'b1; ticks(10);
        btn = 1'b0; ticks(10);
        sw = 16'h0007;
        ticks(3);
        btn = 1'b1;
        ticks(N + 3);
        set_addr(16'h8000, 1'b1);
        n_cmp++; if (bus_if.SWData !== 32'h5) begin n_err++; $display("FAIL race_old got %h want %h", bus_if.SWData, 32'h5); end
        tick();
        set_addr(16'h8001, 1'b0);
        n_cmp++; if (bus_if.SWData !== 32'h1) begin n_err++; $display("FAIL race_stat got %h want %h", bus_if.SWData, 32'h1); end
        set_addr(16'h8000, 1'b0);
        n_cmp++; if (bus_if.SWData !== 32'h7) begin n_err++; $display("FAIL race_new got %h want %h", bus_if.SWData, 32'h7); end
        btn = 1'b0; ticks(10);
        set_addr(16'h8000, 1'b1); tick();
        set_addr(16'h8000, 1'b0);
    endtask

    task automatic test_reset_and_chatter();
        btn = 1'b1; ticks(4);
        rst = 1'b0; btn = 1'b0; ticks(2);
        rst = 1'b1; ticks(12);
        set_addr(16'h8001, 1'b0);
        n_cmp++; if (bus_if.SWData !== 32'h0 || ready_led !== 1'b0) begin n_err++; $display("FAIL reset_abort got %h/%b want 0/0", bus_if.SWData, ready_led); end
        sw = 16'h00C4;
        btn = 1'b1; ticks(10);
        for (int k = 0; k < 4; k++) begin
            btn = k[0]; ticks(2);
        end
        btn = 1'b0; ticks(12);
        n_cmp++; if (bus_if.SWData !== 32'h1) begin n_err++; $display("FAIL chatter_stat got %h want %h", bus_if.SWData, 32'h1); end
        set_addr(16'h8000, 1'b1);
        n_cmp++; if (bus_if.SWData !== 32'h00C4) begin n_err++; $display("FAIL chatter_data got %h want %h", bus_if.SWData, 32'h00C4); end
        tick();
        set_addr(16'h8000, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int seg = 0; seg < 60; seg++) begin
            btn = ($urandom_range(0, 2) != 0) ? ~btn : btn;
            for (int c = 0; c < int'($urandom_range(1, 9)); c++) begin
                if ($urandom_range(0, 5) == 0) sw = 16'($urandom);
                rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
                case ($urandom_range(0, 4))
                    0:       a = 16'h8000;
                    1:       a = 16'h8001;
                    2:       a = 16'h8002;
                    3:       a = 16'h8003;
                    default: a = 16'($urandom);
                endcase
                set_addr(a, ($urandom_range(0, 3) == 0));
                n_cmp++; if (bus_if.SWData !== model_swdata(a)) begin n_err++; $display("FAIL rand_swdata addr %h got %h want %h", a, bus_if.SWData, model_swdata(a)); end
                n_cmp++; if (ready_led !== m_ready) begin n_err++; $display("FAIL rand_led got %b want %b", ready_led, m_ready); end
                tick();
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        bus_if.read_address = 16'h0;
        bus_if.read_enable  = 1'b0;
        rst = 1'b0; sw = '0; btn = 1'b0;
        test_reset();
        test_commit_read();
        test_short_pulse();
        test_two_presses();
        test_read_at_commit();
        test_reset_and_chatter();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
